safety_tcm_axi_slave: RTL and testbench

SAFETY_TCM_AXI_SLAVE -- requirements
Module: safety_tcm_axi_slave

---
 rtl/safety_island_pkg.sv | 29 ++
 rtl/safety_tcm_ram.sv | 30 +++
 rtl/safety_tcm_axi_slave.sv | 204 ++++++++++++++++++++
 tb/tb_safety_tcm_axi_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/safety_island_pkg.sv
// Shared types and encodings for the safety-island TCM slave.
package safety_island_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_DATA  = 2'd2,
    ST_WR_RESP  = 2'd3
  } tcm_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_64B = 3'b011;

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // Next word address; bit 29 is the carry out of the 32-bit byte space.
  function automatic logic [29:0] step_word(input logic [28:0] word, input logic [1:0] burst);
    return (burst == BURST_INCR) ? ({1'b0, word} + 30'd1) : {1'b0, word};
  endfunction

endpackage

// File: rtl/safety_tcm_ram.sv
// Single-port 64-bit TCM storage with byte write enables and registered read.
module safety_tcm_ram
  import safety_island_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_we,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 8; b++) begin
        if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/safety_tcm_axi_slave.sv
// AXI4 slave front-end for the safety-island TCM; one transaction in flight at a time.
// state       | meaning
// ST_IDLE     | waiting for AR/AW, arbitration active
// ST_RD_BURST | returning read beats
// ST_WR_DATA  | accepting write beats
// ST_WR_RESP  | holding write response until accepted
module safety_tcm_axi_slave
  import safety_island_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] axi_araddr_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [2:0]  axi_arsize_i,
  input  logic [1:0]  axi_arburst_i,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [2:0]  axi_awsize_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [63:0] axi_wdata_i,
  input  logic [7:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  output logic [63:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic        axi_rlast_o,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [1:0]  axi_bresp_o,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  tcm_state_e  r_state, w_state_nxt;
  logic        r_rdy_en;
  logic        r_prio_wr;
  logic [28:0] r_word;
  logic        r_wrapped;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [1:0]  r_burst;
  logic        r_size_err;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [1:0]  r_bresp;

  logic        w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_last;
  logic [29:0] w_step;
  logic [28:0] w_beat_word;
  logic        w_beat_wrap;
  logic [1:0]  w_beat_burst;
  logic        w_beat_szerr;
  logic [28:0] w_off;
  logic        w_in_range;
  logic        w_beat_err;
  logic        w_ram_en;
  logic [7:0]  w_ram_we;
  logic [63:0] w_ram_rdata;
  logic        w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^{axi_araddr_i[2:0], axi_awaddr_i[2:0]};

  // Arbitration: the side not currently favoured only loses when both request.
  assign axi_arready_o = (r_state == ST_IDLE) && r_rdy_en && !(axi_awvalid_i && r_prio_wr);
  assign axi_awready_o = (r_state == ST_IDLE) && r_rdy_en && !(axi_arvalid_i && !r_prio_wr);
  assign axi_wready_o  = (r_state == ST_WR_DATA);
  assign axi_bvalid_o  = (r_state == ST_WR_RESP);
  assign axi_bresp_o   = r_bresp;
  assign axi_rvalid_o  = r_rvalid;
  assign axi_rresp_o   = r_rresp;
  assign axi_rlast_o   = r_rvalid && w_last;
  assign axi_rdata_o   = (r_rvalid && (r_rresp == RESP_OKAY)) ? w_ram_rdata : 64'h0;

  assign w_ar_hs = axi_arvalid_i && axi_arready_o;
  assign w_aw_hs = axi_awvalid_i && axi_awready_o;
  assign w_r_hs  = r_rvalid && axi_rready_i;
  assign w_w_hs  = axi_wvalid_i && axi_wready_o;
  assign w_last  = (r_beat == r_len);
  assign w_step  = step_word(r_word, r_burst);

  // The beat whose address drives the RAM this cycle: the new AR, the next read beat, or the current write beat.
  always_comb begin
    w_beat_word  = r_word;
    w_beat_wrap  = r_wrapped;
    w_beat_burst = r_burst;
    w_beat_szerr = r_size_err;
    w_ram_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs) begin
          w_beat_word  = axi_araddr_i[31:3];
          w_beat_wrap  = 1'b0;
          w_beat_burst = axi_arburst_i;
          w_beat_szerr = (axi_arsize_i != SIZE_64B);
          w_ram_en     = 1'b1;
        end
      end
      ST_RD_BURST: begin
        w_beat_word = w_step[28:0];
        w_beat_wrap = r_wrapped || w_step[29];
        w_ram_en    = w_r_hs && !w_last;
      end
      ST_WR_DATA: w_ram_en = w_w_hs;
      default: ;
    endcase
  end

  assign w_off      = w_beat_word - BASE_ADDR[31:3];
  assign w_in_range = ({3'b000, w_off} < 32'(MEM_DEPTH));
  assign w_beat_err = !burst_ok(w_beat_burst) || w_beat_szerr || w_beat_wrap || !w_in_range;
  assign w_ram_we   = ((r_state == ST_WR_DATA) && w_w_hs && !w_beat_err) ? axi_wstrb_i : 8'h00;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs)      w_state_nxt = ST_RD_BURST;
        else if (w_aw_hs) w_state_nxt = ST_WR_DATA;
      end
      ST_RD_BURST: if (w_r_hs && w_last) w_state_nxt = ST_IDLE;
      ST_WR_DATA:  if (w_w_hs && w_last) w_state_nxt = ST_WR_RESP;
      ST_WR_RESP:  if (axi_bready_i)     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_rdy_en   <= 1'b0;
      r_prio_wr  <= 1'b0;
      r_word     <= '0;
      r_wrapped  <= 1'b0;
      r_len      <= '0;
      r_beat     <= '0;
      r_burst    <= BURST_FIXED;
      r_size_err <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
      if (w_ar_hs && axi_awvalid_i)      r_prio_wr <= 1'b1;
      else if (w_aw_hs && axi_arvalid_i) r_prio_wr <= 1'b0;

      if (w_ar_hs) begin
        r_word     <= axi_araddr_i[31:3];
        r_wrapped  <= 1'b0;
        r_len      <= axi_arlen_i;
        r_burst    <= axi_arburst_i;
        r_size_err <= (axi_arsize_i != SIZE_64B);
        r_beat     <= '0;
        r_rvalid   <= 1'b1;
        r_rresp    <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
      end else if (w_aw_hs) begin
        r_word     <= axi_awaddr_i[31:3];
        r_wrapped  <= 1'b0;
        r_len      <= axi_awlen_i;
        r_burst    <= axi_awburst_i;
        r_size_err <= (axi_awsize_i != SIZE_64B);
        r_beat     <= '0;
        r_bresp    <= RESP_OKAY;
      end else if ((r_state == ST_RD_BURST) && w_r_hs) begin
        if (w_last) begin
          r_rvalid <= 1'b0;
        end else begin
          r_word    <= w_step[28:0];
          r_wrapped <= w_beat_wrap;
          r_beat    <= r_beat + 8'd1;
          r_rresp   <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
        end
      end else if ((r_state == ST_WR_DATA) && w_w_hs) begin
        r_word    <= w_step[28:0];
        r_wrapped <= r_wrapped || w_step[29];
        r_beat    <= r_beat + 8'd1;
        if (w_beat_err || (axi_wlast_i != w_last)) r_bresp <= RESP_SLVERR;
      end
    end
  end

  safety_tcm_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_en    (w_ram_en),
    .i_addr  (w_off[AW-1:0]),
    .i_we    (w_ram_we),
    .i_wdata (axi_wdata_i),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_safety_tcm_axi_slave.sv
// Directed scoreboard bench for safety_tcm_axi_slave.
module tb_safety_tcm_axi_slave;

  localparam int unsigned DEPTH = 1024;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] axi_araddr_i;
  logic [7:0]  axi_arlen_i;
  logic [2:0]  axi_arsize_i;
  logic [1:0]  axi_arburst_i;
  logic        axi_arvalid_i;
  logic        axi_arready_o;
  logic [31:0] axi_awaddr_i;
  logic [7:0]  axi_awlen_i;
  logic [2:0]  axi_awsize_i;
  logic [1:0]  axi_awburst_i;
  logic        axi_awvalid_i;
  logic        axi_awready_o;
  logic [63:0] axi_wdata_i;
  logic [7:0]  axi_wstrb_i;
  logic        axi_wlast_i;
  logic        axi_wvalid_i;
  logic        axi_wready_o;
  logic [63:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic        axi_rlast_o;
  logic        axi_rvalid_o;
  logic        axi_rready_i;
  logic [1:0]  axi_bresp_o;
  logic        axi_bvalid_o;
  logic        axi_bready_i;

  safety_tcm_axi_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i), .axi_arsize_i(axi_arsize_i),
    .axi_arburst_i(axi_arburst_i), .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i), .axi_awsize_i(axi_awsize_i),
    .axi_awburst_i(axi_awburst_i), .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o), .axi_rlast_o(axi_rlast_o),
    .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
    .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      exp_r[$];
  logic [1:0]  exp_b[$];
  logic [63:0] mem_model [DEPTH];
  int          total = 0;
  int          bad = 0;

  logic [31:0] wc_addr;
  logic [7:0]  wc_len;
  logic [1:0]  wc_burst;
  logic [2:0]  wc_size;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference beat decode: byte address of beat i computed directly, not stepped.
  function automatic void beat_info(input logic [31:0] a, input int i, input logic [1:0] burst,
                                    input logic [2:0] size, output bit err, output int unsigned word);
    logic [32:0] full;
    full = {1'b0, a[31:3], 3'b000};
    if (burst == 2'b01) full = full + 33'(i) * 33'd8;
    word = 32'(full[31:3]);
    err = (size != 3'b011) || (burst > 2'b01) || full[32] || (word >= DEPTH);
  endfunction

  task automatic push_rd_exp(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size);
    bit err;
    int unsigned word;
    rbeat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      beat_info(a, i, burst, size, err, word);
      b.resp = err ? 2'b10 : 2'b00;
      b.data = err ? 64'h0 : mem_model[word];
      b.last = (i == int'(len));
      exp_r.push_back(b);
    end
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                        input logic [2:0] size);
    axi_araddr_i = a; axi_arlen_i = len; axi_arburst_i = burst; axi_arsize_i = size;
    push_rd_exp(a, len, burst, size);
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                        input logic [2:0] size);
    axi_awaddr_i = a; axi_awlen_i = len; axi_awburst_i = burst; axi_awsize_i = size;
    wc_addr = a; wc_len = len; wc_burst = burst; wc_size = size;
  endtask

  // Called at a falling edge; returns at the falling edge after the AR handshake.
  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size);
    int cyc = 0;
    set_ar(a, len, burst, size);
    axi_arvalid_i = 1'b1;
    #1;
    while (!axi_arready_o && cyc < 50) begin @(negedge clk_i); #1; cyc++; end
    chk("ar_accept", 64'(axi_arready_o), 64'd1);
    @(negedge clk_i);
    axi_arvalid_i = 1'b0;
    chk("rvalid_latency", 64'(axi_rvalid_o), 64'd1);
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size);
    int cyc = 0;
    set_aw(a, len, burst, size);
    axi_awvalid_i = 1'b1;
    #1;
    while (!axi_awready_o && cyc < 50) begin @(negedge clk_i); #1; cyc++; end
    chk("aw_accept", 64'(axi_awready_o), 64'd1);
    @(negedge clk_i);
    axi_awvalid_i = 1'b0;
  endtask

  task automatic read_beats(input int n, input bit toggle, input bit final_chk);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [63:0] hd;
    logic [1:0]  hr;
    logic        hl;
    rbeat_t e;
    while (got < n && cyc < 200) begin
      axi_rready_i = toggle ? cyc[0] : 1'b1;
      #1;
      if (axi_rvalid_o === 1'b1) begin
        if (stalled) begin
          chk("hold_rdata", axi_rdata_o, hd);
          chk("hold_rresp", 64'(axi_rresp_o), 64'(hr));
          chk("hold_rlast", 64'(axi_rlast_o), 64'(hl));
        end
        if (axi_rready_i && exp_r.size() > 0) begin
          e = exp_r.pop_front();
          chk("rdata", axi_rdata_o, e.data);
          chk("rresp", 64'(axi_rresp_o), 64'(e.resp));
          chk("rlast", 64'(axi_rlast_o), 64'(e.last));
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = axi_rdata_o; hr = axi_rresp_o; hl = axi_rlast_o;
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    axi_rready_i = 1'b0;
    chk("r_beat_count", 64'(got), 64'(n));
    if (got < n) exp_r.delete();
    if (final_chk) chk("rvalid_done", 64'(axi_rvalid_o), 64'd0);
  endtask

  // last_mode: 0 correct wlast, 1 wlast missing on final beat, 2 wlast on first beat only
  task automatic send_w(input logic [63:0] data0, input logic [63:0] dinc, input logic [7:0] strb,
                        input int last_mode);
    bit berr = 0;
    bit err;
    int unsigned word;
    int cyc;
    logic [63:0] d;
    logic wl;
    for (int i = 0; i <= int'(wc_len); i++) begin
      beat_info(wc_addr, i, wc_burst, wc_size, err, word);
      d = data0 + dinc * 64'(i);
      wl = (last_mode == 0) ? (i == int'(wc_len)) : (last_mode == 1) ? 1'b0 : (i == 0);
      if (wl != (i == int'(wc_len))) berr = 1;
      if (err) berr = 1;
      else for (int b = 0; b < 8; b++) if (strb[b]) mem_model[word][b*8 +: 8] = d[b*8 +: 8];
      axi_wdata_i = d; axi_wstrb_i = strb; axi_wlast_i = wl; axi_wvalid_i = 1'b1;
      #1;
      cyc = 0;
      while (!axi_wready_o && cyc < 50) begin @(negedge clk_i); #1; cyc++; end
      chk("w_accept", 64'(axi_wready_o), 64'd1);
      @(negedge clk_i);
    end
    axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
    exp_b.push_back(berr ? 2'b10 : 2'b00);
    chk("bvalid_latency", 64'(axi_bvalid_o), 64'd1);
    @(negedge clk_i);
    chk("bvalid_hold", 64'(axi_bvalid_o), 64'd1);
    axi_bready_i = 1'b1;
    #1;
    chk("bresp", 64'(axi_bresp_o), 64'(exp_b.pop_front()));
    @(negedge clk_i);
    axi_bready_i = 1'b0;
    chk("bvalid_clear", 64'(axi_bvalid_o), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arready"}, 64'(axi_arready_o), 64'd0);
    chk({tag, "_awready"}, 64'(axi_awready_o), 64'd0);
    chk({tag, "_wready"},  64'(axi_wready_o),  64'd0);
    chk({tag, "_rvalid"},  64'(axi_rvalid_o),  64'd0);
    chk({tag, "_bvalid"},  64'(axi_bvalid_o),  64'd0);
    chk({tag, "_rdata"},   axi_rdata_o,        64'd0);
    chk({tag, "_rresp"},   64'(axi_rresp_o),   64'd0);
    chk({tag, "_rlast"},   64'(axi_rlast_o),   64'd0);
    chk({tag, "_bresp"},   64'(axi_bresp_o),   64'd0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    axi_araddr_i = '0; axi_arlen_i = '0; axi_arsize_i = 3'b011; axi_arburst_i = 2'b01; axi_arvalid_i = 1'b0;
    axi_awaddr_i = '0; axi_awlen_i = '0; axi_awsize_i = 3'b011; axi_awburst_i = 2'b01; axi_awvalid_i = 1'b0;
    axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0; axi_wvalid_i = 1'b0;
    axi_rready_i = 1'b0; axi_bready_i = 1'b0;
    wc_addr = '0; wc_len = '0; wc_burst = 2'b01; wc_size = 3'b011;
    for (int i = 0; i < int'(DEPTH); i++) mem_model[i] = 64'h0;

    // reset state and release timing
    repeat (3) @(negedge clk_i);
    chk_all_zero("rst");
    rst_n_i = 1'b1;
    #1 chk("arready_at_release", 64'(axi_arready_o), 64'd0);
    @(negedge clk_i);
    #1 chk("arready_after_release", 64'(axi_arready_o), 64'd1);

    // prefill words 0..3
    send_aw(32'h0, 8'd3, 2'b01, 3'b011);
    send_w(64'h0123_4567_89AB_CDE0, 64'd1, 8'hFF, 0);

    // first contest: read wins, pending write follows
    set_ar(32'h0, 8'd0, 2'b01, 3'b011);
    set_aw(32'h18, 8'd0, 2'b01, 3'b011);
    axi_arvalid_i = 1'b1; axi_awvalid_i = 1'b1;
    #1;
    chk("arb1_arready", 64'(axi_arready_o), 64'd1);
    chk("arb1_awready", 64'(axi_awready_o), 64'd0);
    @(negedge clk_i);
    axi_arvalid_i = 1'b0;
    chk("arb1_rvalid", 64'(axi_rvalid_o), 64'd1);
    read_beats(1, 1'b0, 1'b1);
    #1 chk("arb1_aw_next", 64'(axi_awready_o), 64'd1);
    @(negedge clk_i);
    axi_awvalid_i = 1'b0;
    send_w(64'h5555_6666_7777_8888, 64'd0, 8'hFF, 0);

    // second contest: write wins this time
    set_ar(32'h18, 8'd0, 2'b01, 3'b011);
    set_aw(32'h20, 8'd0, 2'b01, 3'b011);
    axi_arvalid_i = 1'b1; axi_awvalid_i = 1'b1;
    #1;
    chk("arb2_awready", 64'(axi_awready_o), 64'd1);
    chk("arb2_arready", 64'(axi_arready_o), 64'd0);
    @(negedge clk_i);
    axi_awvalid_i = 1'b0;
    send_w(64'h0BAD_F00D_CAFE_0020, 64'd0, 8'hFF, 0);
    #1 chk("arb2_ar_next", 64'(axi_arready_o), 64'd1);
    @(negedge clk_i);
    axi_arvalid_i = 1'b0;
    chk("arb2_rvalid", 64'(axi_rvalid_o), 64'd1);
    read_beats(1, 1'b0, 1'b1);

    // single write then read of 0x10
    send_aw(32'h10, 8'd0, 2'b01, 3'b011);
    send_w(64'h1122_3344_5566_7788, 64'd0, 8'hFF, 0);
    send_ar(32'h10, 8'd0, 2'b01, 3'b011);
    read_beats(1, 1'b0, 1'b1);

    // INCR read with rready toggling
    send_ar(32'h0, 8'd3, 2'b01, 3'b011);
    read_beats(4, 1'b1, 1'b1);

    // partial strobe over a zero word
    send_aw(32'h0, 8'd0, 2'b01, 3'b011);
    send_w(64'h0, 64'd0, 8'hFF, 0);
    send_aw(32'h0, 8'd0, 2'b01, 3'b011);
    send_w(64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 8'h0F, 0);
    send_ar(32'h0, 8'd0, 2'b01, 3'b011);
    read_beats(1, 1'b0, 1'b1);

    // end-of-memory boundary
    send_aw(32'(8 * (DEPTH - 2)), 8'd1, 2'b01, 3'b011);
    send_w(64'hDEAD_BEEF_0000_0000, 64'd1, 8'hFF, 0);
    send_aw(32'(8 * (DEPTH - 1)), 8'd1, 2'b01, 3'b011);
    send_w(64'hFEED_0000_0000_0100, 64'd1, 8'hFF, 0);
    send_ar(32'(8 * (DEPTH - 2)), 8'd3, 2'b01, 3'b011);
    read_beats(4, 1'b0, 1'b1);

    // burst/size errors and FIXED burst
    send_aw(32'h20, 8'd0, 2'b10, 3'b011);
    send_w(64'hFFFF_0000_FFFF_0000, 64'd0, 8'hFF, 0);
    send_ar(32'h20, 8'd0, 2'b00, 3'b011);
    read_beats(1, 1'b0, 1'b1);
    send_ar(32'h10, 8'd0, 2'b01, 3'b010);
    read_beats(1, 1'b0, 1'b1);
    send_ar(32'h10, 8'd1, 2'b10, 3'b011);
    read_beats(2, 1'b0, 1'b1);
    send_ar(32'h10, 8'd2, 2'b00, 3'b011);
    read_beats(3, 1'b0, 1'b1);
    send_aw(32'h20, 8'd0, 2'b01, 3'b001);
    send_w(64'h1357_9BDF_0246_8ACE, 64'd0, 8'hFF, 0);
    send_ar(32'h20, 8'd0, 2'b01, 3'b011);
    read_beats(1, 1'b0, 1'b1);

    // wlast protocol errors still write data
    send_aw(32'h28, 8'd1, 2'b01, 3'b011);
    send_w(64'h2828_0000_0000_0000, 64'd1, 8'hFF, 1);
    send_aw(32'h38, 8'd1, 2'b01, 3'b011);
    send_w(64'h3838_0000_0000_0000, 64'd1, 8'hFF, 2);
    send_ar(32'h28, 8'd3, 2'b01, 3'b011);
    read_beats(4, 1'b0, 1'b1);

    // 32-bit address wrap
    send_ar(32'hFFFF_FFF8, 8'd1, 2'b01, 3'b011);
    read_beats(2, 1'b0, 1'b1);

    // reset in the middle of an 8-beat read
    send_ar(32'h0, 8'd7, 2'b01, 3'b011);
    read_beats(3, 1'b0, 1'b0);
    rst_n_i = 1'b0;
    #1 chk_all_zero("midrst");
    exp_r.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1 chk("arready_midrst_release", 64'(axi_arready_o), 64'd0);
    @(negedge clk_i);
    send_ar(32'h10, 8'd0, 2'b01, 3'b011);
    read_beats(1, 1'b0, 1'b1);
    send_aw(32'h30, 8'd0, 2'b01, 3'b011);
    send_w(64'h3030_3030_3030_3030, 64'd0, 8'hFF, 0);
    send_ar(32'h30, 8'd0, 2'b01, 3'b011);
    read_beats(1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
